// File: rtl/rhs2116_link_deframer.sv
// rhs2116_link_deframer
// ---------------------------------------------------------------------------
// Receive-side deframer for the RHS2116 coax link. It takes the recovered
// serial bitstream (one bit per bit_valid strobe), hunts for the sync byte,
// acquires and holds lock, and extracts the frame counter and the 32-bit
// sensor word. Each delivered word is flagged with CRC and counter-gap status.
//
// Frame (56 bits, MSB first): SYNC_WORD[7:0] counter[7:0] payload[31:0] crc[7:0]
//
// Ports:
//   clk_sys        system clock, rising edge
//   rst_n          asynchronous active-low reset
//   enable         deframer enable; low forces HUNT and drops lock
//   bit_in         recovered serial bit
//   bit_valid      bit_in is valid this cycle
//   data_out       extracted sensor word (holds between pulses)
//   frame_cnt_out  frame counter received with data_out
//   data_valid     one-cycle pulse; data_out/frame_cnt_out/crc_err/frame_gap valid
//   crc_err        CRC-8 mismatch on the delivered frame
//   frame_gap      counter is not previous+1 (mod 256)
//   locked         link lock indicator
//   sync_loss      one-cycle pulse when lock is dropped
//
// Optional feature: define RHS_DEFRAMER_CRC_EN to build the CRC-8
// (poly 0x07, init 0x00) generator and compare. Without it the crc byte is
// consumed only to keep framing and crc_err stays 0.
// ---------------------------------------------------------------------------
module rhs2116_link_deframer #(
    parameter logic [7:0] SYNC_WORD    = 8'hA5,
    parameter int          LOCK_COUNT   = 2,
    parameter int          UNLOCK_COUNT = 3
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic [31:0] data_out,
    output logic [7:0]  frame_cnt_out,
    output logic        data_valid,
    output logic        crc_err,
    output logic        frame_gap,
    output logic        locked,
    output logic        sync_loss
);

    localparam logic [3:0] LOCK_TH   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_TH = 4'(UNLOCK_COUNT);

    typedef enum logic [1:0] {HUNT, BODY, SYNC_CHK} state_t;

    state_t      state;
    logic [7:0]  sync_sr;      // last 8 consumed bits, shifted on every consumed bit
    logic [5:0]  bit_cnt;      // bit position inside BODY (0..47) or SYNC_CHK (0..7)
    logic [39:0] body_sr;      // counter + payload of the current frame
    logic [3:0]  good_cnt;
    logic [3:0]  bad_cnt;
    logic        have_prev;    // a frame has been delivered since lock was acquired
    logic [7:0]  prev_cnt;
    logic        pend_valid;   // frame completed while locked; deliver next edge

    logic [7:0]  sync_next;
    logic        sync_hit;
    logic [3:0]  good_inc;
    logic [3:0]  bad_inc;
    logic [7:0]  cnt_expect;
    logic        gap_det;
    logic        crc_bad;

    assign sync_next  = {sync_sr[6:0], bit_in};
    assign sync_hit   = (sync_next == SYNC_WORD);
    assign good_inc   = (good_cnt == 4'hF) ? good_cnt : good_cnt + 4'd1;
    assign bad_inc    = (bad_cnt == 4'hF) ? bad_cnt : bad_cnt + 4'd1;
    assign cnt_expect = prev_cnt + 8'd1;
    assign gap_det    = have_prev && (body_sr[39:32] != cnt_expect);

`ifdef RHS_DEFRAMER_CRC_EN
    logic [7:0] crc_reg;       // running CRC over counter + payload
    logic [7:0] rx_crc;        // received crc byte
    logic [7:0] crc_step;

    // One serial CRC-8 step, MSB first, poly x^8+x^2+x+1.
    assign crc_step = {crc_reg[6:0], 1'b0} ^ ((crc_reg[7] ^ bit_in) ? 8'h07 : 8'h00);
    assign crc_bad  = (crc_reg != rx_crc);

    // crc_reg is cleared by every consumed bit outside BODY, so it starts at 0
    // for each frame. Delivery reads it on the edge right after the last body
    // bit, before any sync bit can clear it.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            crc_reg <= 8'h00;
            rx_crc  <= 8'h00;
        end else if (!enable) begin
            crc_reg <= 8'h00;
        end else if (bit_valid) begin
            if (state == BODY) begin
                if (bit_cnt < 6'd40)
                    crc_reg <= crc_step;
                else
                    rx_crc <= {rx_crc[6:0], bit_in};
            end else begin
                crc_reg <= 8'h00;
            end
        end
    end
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state         <= HUNT;
            sync_sr       <= 8'h00;
            bit_cnt       <= 6'd0;
            body_sr       <= 40'd0;
            good_cnt      <= 4'd0;
            bad_cnt       <= 4'd0;
            have_prev     <= 1'b0;
            prev_cnt      <= 8'h00;
            pend_valid    <= 1'b0;
            data_out      <= 32'd0;
            frame_cnt_out <= 8'h00;
            data_valid    <= 1'b0;
            crc_err       <= 1'b0;
            frame_gap     <= 1'b0;
            locked        <= 1'b0;
            sync_loss     <= 1'b0;
        end else if (!enable) begin
            // Drop everything; a frame in flight (or awaiting delivery) is lost.
            state      <= HUNT;
            sync_sr    <= 8'h00;
            bit_cnt    <= 6'd0;
            good_cnt   <= 4'd0;
            bad_cnt    <= 4'd0;
            have_prev  <= 1'b0;
            pend_valid <= 1'b0;
            data_valid <= 1'b0;
            crc_err    <= 1'b0;
            frame_gap  <= 1'b0;
            locked     <= 1'b0;
            sync_loss  <= locked;
        end else begin
            sync_loss  <= 1'b0;
            pend_valid <= 1'b0;
            data_valid <= pend_valid;
            crc_err    <= pend_valid & crc_bad;
            frame_gap  <= pend_valid & gap_det;
            if (pend_valid) begin
                data_out      <= body_sr[31:0];
                frame_cnt_out <= body_sr[39:32];
                prev_cnt      <= body_sr[39:32];
                have_prev     <= 1'b1;
            end

            if (bit_valid) begin
                sync_sr <= sync_next;
                case (state)
                    HUNT: begin
                        if (sync_hit) begin
                            good_cnt <= 4'd1;
                            if (LOCK_TH <= 4'd1)
                                locked <= 1'b1;
                            state   <= BODY;
                            bit_cnt <= 6'd0;
                        end
                    end
                    BODY: begin
                        // The crc byte (bits 40..47) is counted but not kept here.
                        if (bit_cnt < 6'd40)
                            body_sr <= {body_sr[38:0], bit_in};
                        if (bit_cnt == 6'd47) begin
                            state      <= SYNC_CHK;
                            bit_cnt    <= 6'd0;
                            pend_valid <= locked;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    SYNC_CHK: begin
                        if (bit_cnt != 6'd7) begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end else begin
                            bit_cnt <= 6'd0;
                            if (sync_hit) begin
                                good_cnt <= good_inc;
                                bad_cnt  <= 4'd0;
                                if (good_inc >= LOCK_TH)
                                    locked <= 1'b1;
                                state <= BODY;
                            end else if (!locked) begin
                                good_cnt <= 4'd0;
                                state    <= HUNT;
                            end else begin
                                good_cnt <= 4'd0;
                                if (bad_inc >= UNLOCK_TH) begin
                                    bad_cnt   <= 4'd0;
                                    locked    <= 1'b0;
                                    sync_loss <= 1'b1;
                                    have_prev <= 1'b0;
                                    state     <= HUNT;
                                end else begin
                                    // Flywheel: trust the frame timing and keep delivering.
                                    bad_cnt <= bad_inc;
                                    state   <= BODY;
                                end
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule
